// File: rtl/bsg_cache_sbuf_drain.sv
// bsg_cache_sbuf_drain
// Pops the head store-buffer entry and issues it as a masked write on the
// shared, way-interleaved data-mem port. DMA always wins the port. The
// pipeline read wins until the sbuf has been blocked starve_limit_p cycles,
// after which stall_o holds the pipeline off and the sbuf is forced through.
module bsg_cache_sbuf_drain #(
   parameter int addr_width_p          = 32,
   parameter int data_width_p          = 32,
   parameter int ways_p                = 8,
   parameter int sets_p                = 64,
   parameter int block_size_in_words_p = 8,
   parameter int starve_limit_p        = 4,
   // Enables the check that the pipeline honours stall_o; an environment
   // that deliberately drives a read into a forced cycle can turn it off.
   parameter bit assert_protocol_p     = 1'b1,
   localparam int lg_ways        = $clog2(ways_p),
   localparam int lg_sets        = $clog2(sets_p),
   localparam int lg_block       = $clog2(block_size_in_words_p),
   localparam int mask_w         = data_width_p / 8,
   localparam int entry_w        = addr_width_p + data_width_p + mask_w + lg_ways,
   localparam int dm_addr_w      = lg_sets + lg_block,
   localparam int dm_data_w      = ways_p * data_width_p,
   localparam int dm_mask_w      = dm_data_w / 8
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [entry_w-1:0]   sbuf_entry_i,
   input  logic                 sbuf_v_i,
   output logic                 sbuf_yumi_o,
   input  logic                 pipe_dmem_v_i,
   input  logic                 dma_dmem_v_i,
   output logic                 stall_o,
   output logic                 data_mem_v_o,
   output logic                 data_mem_w_o,
   output logic [dm_addr_w-1:0] data_mem_addr_o,
   output logic [dm_data_w-1:0] data_mem_data_o,
   output logic [dm_mask_w-1:0] data_mem_mask_o
);

   localparam int lg_data_bytes = $clog2(mask_w);
   localparam int dm_addr_hi    = dm_addr_w + lg_data_bytes - 1;
   localparam int wait_w        = $clog2(starve_limit_p + 1);
   localparam logic [wait_w-1:0] limit_lp = wait_w'(starve_limit_p);

   // Starvation count, saturating at the limit.
   function automatic logic [wait_w-1:0] sat_inc(input logic [wait_w-1:0] v);
      return (v >= limit_lp) ? limit_lp : v + 1'b1;
   endfunction

   // Place the entry byte mask in the lane of the selected way only.
   function automatic logic [dm_mask_w-1:0] expand_mask(input logic [lg_ways-1:0] way,
                                                         input logic [mask_w-1:0]  m);
      logic [dm_mask_w-1:0] r;
      r = '0;
      for (int w = 0; w < ways_p; w++) begin
         if (way == lg_ways'(w)) r[w*mask_w +: mask_w] = m;
      end
      return r;
   endfunction

   logic [addr_width_p-1:0] entry_addr;
   logic [data_width_p-1:0] entry_data;
   logic [mask_w-1:0]       entry_mask;
   logic [lg_ways-1:0]      entry_way;

   assign entry_way  = sbuf_entry_i[lg_ways-1:0];
   assign entry_mask = sbuf_entry_i[lg_ways +: mask_w];
   assign entry_data = sbuf_entry_i[lg_ways+mask_w +: data_width_p];
   assign entry_addr = sbuf_entry_i[entry_w-1 -: addr_width_p];

   // Tag and offset-within-word address bits do not address the data mem.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{entry_addr[addr_width_p-1:dm_addr_hi+1],
                               entry_addr[lg_data_bytes-1:0]};

   logic [wait_w-1:0] wait_q, wait_d;
   logic              force_w;
   logic              gnt;

   assign force_w = (wait_q == limit_lp);
   assign gnt     = sbuf_v_i & ~reset_i & ~dma_dmem_v_i & (~pipe_dmem_v_i | force_w);

   // Grant decode, data-mem write drive and starvation-count next state.
   always_comb begin
      sbuf_yumi_o     = 1'b0;
      data_mem_v_o    = 1'b0;
      data_mem_w_o    = 1'b0;
      data_mem_addr_o = '0;
      data_mem_data_o = '0;
      data_mem_mask_o = '0;
      stall_o         = force_w & ~reset_i;
      wait_d          = '0;

      if (gnt) begin
         sbuf_yumi_o     = 1'b1;
         data_mem_v_o    = 1'b1;
         data_mem_w_o    = 1'b1;
         data_mem_addr_o = entry_addr[dm_addr_hi:lg_data_bytes];
         data_mem_data_o = {ways_p{entry_data}};
         data_mem_mask_o = expand_mask(entry_way, entry_mask);
      end

      if (sbuf_v_i && !gnt) wait_d = sat_inc(wait_q);
   end

   // Starvation counter register.
   always_ff @(posedge clk_i) begin
      if (reset_i) wait_q <= '0;
      else         wait_q <= wait_d;
   end

   // Protocol and X checks on the outputs outside reset.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!sbuf_yumi_o || sbuf_v_i)
           else $error("sbuf_yumi_o asserted without sbuf_v_i");
         assert (!$isunknown({sbuf_yumi_o, stall_o, data_mem_v_o, data_mem_w_o,
                              data_mem_addr_o, data_mem_data_o, data_mem_mask_o}))
           else $error("unknown value on an output");
         if (assert_protocol_p) begin
            assert (!(pipe_dmem_v_i && force_w))
              else $error("pipeline read issued while stall_o was set");
         end
      end
   end

endmodule

// File: tb/tb_bsg_cache_sbuf_drain.sv
// Directed bench for bsg_cache_sbuf_drain: one task per scenario, inline checks.
module tb_bsg_cache_sbuf_drain;

   logic         clk_i = 1'b0;
   logic         reset_i = 1'b1;
   logic [70:0]  sbuf_entry_i = '0;
   logic         sbuf_v_i = 1'b0;
   logic         sbuf_yumi_o;
   logic         pipe_dmem_v_i = 1'b0;
   logic         dma_dmem_v_i = 1'b0;
   logic         stall_o;
   logic         data_mem_v_o;
   logic         data_mem_w_o;
   logic [8:0]   data_mem_addr_o;
   logic [255:0] data_mem_data_o;
   logic [31:0]  data_mem_mask_o;

   int errors = 0;
   int checks = 0;

   bsg_cache_sbuf_drain #(.assert_protocol_p(1'b0)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .sbuf_entry_i(sbuf_entry_i), .sbuf_v_i(sbuf_v_i), .sbuf_yumi_o(sbuf_yumi_o),
      .pipe_dmem_v_i(pipe_dmem_v_i), .dma_dmem_v_i(dma_dmem_v_i), .stall_o(stall_o),
      .data_mem_v_o(data_mem_v_o), .data_mem_w_o(data_mem_w_o),
      .data_mem_addr_o(data_mem_addr_o), .data_mem_data_o(data_mem_data_o),
      .data_mem_mask_o(data_mem_mask_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [70:0] mk_entry(input logic [31:0] a, input logic [31:0] d,
                                            input logic [3:0] m, input logic [2:0] w);
      return {a, d, m, w};
   endfunction

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b1; sbuf_v_i = 1'b1; pipe_dmem_v_i = 1'b0; dma_dmem_v_i = 1'b0;
      sbuf_entry_i = mk_entry(32'h0000_0124, 32'hDEADBEEF, 4'hF, 3'd1);
      next_cycle(); next_cycle();
      @(negedge clk_i);
      checks++; if (sbuf_yumi_o !== 1'b0) begin errors++; $display("FAIL reset_yumi got=%b exp=0", sbuf_yumi_o); end
      checks++; if (data_mem_v_o !== 1'b0 || data_mem_w_o !== 1'b0) begin errors++; $display("FAIL reset_vw got=%b%b exp=00", data_mem_v_o, data_mem_w_o); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
      checks++; if (data_mem_mask_o !== 32'h0 || data_mem_addr_o !== 9'h0 || data_mem_data_o !== 256'h0) begin errors++; $display("FAIL reset_bus got mask=%h addr=%h exp 0", data_mem_mask_o, data_mem_addr_o); end
      next_cycle();
      reset_i = 1'b0; sbuf_v_i = 1'b0;
   endtask

   task automatic test_single_write();
      sbuf_entry_i = mk_entry(32'h0000_0124, 32'hDEADBEEF, 4'b0110, 3'd5);
      sbuf_v_i = 1'b1;
      @(negedge clk_i);
      checks++; if ({sbuf_yumi_o, data_mem_v_o, data_mem_w_o} !== 3'b111) begin errors++; $display("FAIL single_vwy got=%b exp=111", {sbuf_yumi_o, data_mem_v_o, data_mem_w_o}); end
      checks++; if (data_mem_addr_o !== 9'h049) begin errors++; $display("FAIL single_addr got=%h exp=049", data_mem_addr_o); end
      checks++; if (data_mem_mask_o !== 32'h0060_0000) begin errors++; $display("FAIL single_mask got=%h exp=00600000", data_mem_mask_o); end
      checks++; if (data_mem_data_o !== {8{32'hDEADBEEF}}) begin errors++; $display("FAIL single_data got=%h", data_mem_data_o); end
      next_cycle();
      sbuf_v_i = 1'b0;
      next_cycle();
   endtask

   task automatic test_pipe_block();
      sbuf_entry_i = mk_entry(32'h0000_0040, 32'h0BADF00D, 4'b0001, 3'd2);
      sbuf_v_i = 1'b1; pipe_dmem_v_i = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk_i);
         checks++; if (sbuf_yumi_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL pipe_block_c%0d got yumi=%b stall=%b exp 0 0", k, sbuf_yumi_o, stall_o); end
         next_cycle();
         checks++; if (dut.wait_q !== 3'(k)) begin errors++; $display("FAIL pipe_wait_c%0d got=%0d exp=%0d", k, dut.wait_q, k); end
      end
      pipe_dmem_v_i = 1'b0;
      @(negedge clk_i);
      checks++; if (sbuf_yumi_o !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL pipe_release got yumi=%b stall=%b exp 1 0", sbuf_yumi_o, stall_o); end
      checks++; if (data_mem_addr_o !== 9'h010) begin errors++; $display("FAIL pipe_release_addr got=%h exp=010", data_mem_addr_o); end
      next_cycle();
      sbuf_v_i = 1'b0;
      checks++; if (dut.wait_q !== 3'd0) begin errors++; $display("FAIL pipe_wait_clear got=%0d exp=0", dut.wait_q); end
      next_cycle();
   endtask

   task automatic test_starve_force();
      sbuf_entry_i = mk_entry(32'h0000_0008, 32'h12345678, 4'b1000, 3'd1);
      sbuf_v_i = 1'b1; pipe_dmem_v_i = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk_i);
         checks++; if (sbuf_yumi_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL starve_c%0d got yumi=%b stall=%b exp 0 0", k, sbuf_yumi_o, stall_o); end
         next_cycle();
      end
      @(negedge clk_i);
      checks++; if (stall_o !== 1'b1 || sbuf_yumi_o !== 1'b1) begin errors++; $display("FAIL starve_force got stall=%b yumi=%b exp 1 1", stall_o, sbuf_yumi_o); end
      checks++; if (data_mem_mask_o !== 32'h0000_0080) begin errors++; $display("FAIL starve_mask got=%h exp=00000080", data_mem_mask_o); end
      next_cycle();
      @(negedge clk_i);
      checks++; if (stall_o !== 1'b0 || sbuf_yumi_o !== 1'b0) begin errors++; $display("FAIL starve_after got stall=%b yumi=%b exp 0 0", stall_o, sbuf_yumi_o); end
      next_cycle();
      sbuf_v_i = 1'b0; pipe_dmem_v_i = 1'b0;
      next_cycle();
   endtask

   task automatic test_dma_block();
      sbuf_entry_i = mk_entry(32'h0000_0100, 32'hCAFEF00D, 4'b0011, 3'd4);
      sbuf_v_i = 1'b1; pipe_dmem_v_i = 1'b1;
      for (int k = 1; k <= 4; k++) next_cycle();
      pipe_dmem_v_i = 1'b0; dma_dmem_v_i = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk_i);
         checks++; if (stall_o !== 1'b1 || sbuf_yumi_o !== 1'b0 || data_mem_v_o !== 1'b0) begin errors++; $display("FAIL dma_hold_c%0d got stall=%b yumi=%b v=%b exp 1 0 0", k, stall_o, sbuf_yumi_o, data_mem_v_o); end
         next_cycle();
      end
      dma_dmem_v_i = 1'b0;
      @(negedge clk_i);
      checks++; if (sbuf_yumi_o !== 1'b1 || stall_o !== 1'b1) begin errors++; $display("FAIL dma_release got yumi=%b stall=%b exp 1 1", sbuf_yumi_o, stall_o); end
      checks++; if (data_mem_mask_o !== 32'h0003_0000 || data_mem_addr_o !== 9'h040) begin errors++; $display("FAIL dma_release_bus got mask=%h addr=%h exp 00030000 040", data_mem_mask_o, data_mem_addr_o); end
      next_cycle();
      sbuf_v_i = 1'b0;
      @(negedge clk_i);
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL dma_stall_clear got=%b exp=0", stall_o); end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      sbuf_v_i = 1'b1;
      sbuf_entry_i = mk_entry(32'h0000_0ABC, 32'h11223344, 4'b1111, 3'd0);
      @(negedge clk_i);
      checks++; if (sbuf_yumi_o !== 1'b1 || data_mem_mask_o !== 32'h0000_000F || data_mem_addr_o !== 9'h0AF) begin errors++; $display("FAIL b2b_first got yumi=%b mask=%h addr=%h exp 1 0000000f 0af", sbuf_yumi_o, data_mem_mask_o, data_mem_addr_o); end
      checks++; if (data_mem_data_o !== {8{32'h11223344}}) begin errors++; $display("FAIL b2b_first_data got=%h", data_mem_data_o); end
      next_cycle();
      sbuf_entry_i = mk_entry(32'h0000_07FC, 32'hA5A5_5A5A, 4'b1001, 3'd7);
      @(negedge clk_i);
      checks++; if (sbuf_yumi_o !== 1'b1 || data_mem_mask_o !== 32'h9000_0000 || data_mem_addr_o !== 9'h1FF) begin errors++; $display("FAIL b2b_second got yumi=%b mask=%h addr=%h exp 1 90000000 1ff", sbuf_yumi_o, data_mem_mask_o, data_mem_addr_o); end
      next_cycle();
      sbuf_entry_i = mk_entry(32'h0000_0004, 32'hFFFF_0000, 4'b0000, 3'd3);
      @(negedge clk_i);
      checks++; if (sbuf_yumi_o !== 1'b1 || data_mem_w_o !== 1'b1 || data_mem_mask_o !== 32'h0) begin errors++; $display("FAIL zero_mask got yumi=%b w=%b mask=%h exp 1 1 00000000", sbuf_yumi_o, data_mem_w_o, data_mem_mask_o); end
      next_cycle();
      sbuf_v_i = 1'b0;
      next_cycle();
   endtask

   task automatic test_reset_mid_drain();
      sbuf_entry_i = mk_entry(32'h0000_0020, 32'h00C0FFEE, 4'b0101, 3'd6);
      sbuf_v_i = 1'b1; pipe_dmem_v_i = 1'b1;
      for (int k = 1; k <= 3; k++) next_cycle();
      checks++; if (dut.wait_q !== 3'd3) begin errors++; $display("FAIL rst_mid_wait got=%0d exp=3", dut.wait_q); end
      reset_i = 1'b1; pipe_dmem_v_i = 1'b0;
      @(negedge clk_i);
      checks++; if ({sbuf_yumi_o, data_mem_v_o, data_mem_w_o, stall_o} !== 4'b0000 || data_mem_mask_o !== 32'h0) begin errors++; $display("FAIL rst_mid_outputs got=%b mask=%h exp 0000 0", {sbuf_yumi_o, data_mem_v_o, data_mem_w_o, stall_o}, data_mem_mask_o); end
      next_cycle();
      reset_i = 1'b0;
      checks++; if (dut.wait_q !== 3'd0) begin errors++; $display("FAIL rst_mid_wait_clear got=%0d exp=0", dut.wait_q); end
      @(negedge clk_i);
      checks++; if (sbuf_yumi_o !== 1'b1 || data_mem_mask_o !== 32'h0500_0000 || data_mem_addr_o !== 9'h008) begin errors++; $display("FAIL rst_mid_gnt got yumi=%b mask=%h addr=%h exp 1 05000000 008", sbuf_yumi_o, data_mem_mask_o, data_mem_addr_o); end
      next_cycle();
      sbuf_v_i = 1'b0;
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_pipe_block();
      test_starve_force();
      test_dma_block();
      test_back_to_back();
      test_reset_mid_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
